// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: byte-wide ready/valid input, DEPTH-entry circular FIFO,
// and a 10-bit (start, 8 data LSB first, stop) serial shifter with a fixed
// baud divider. serial_out comes straight from a flop so the line never glitches.
//
// Handshake: a byte is taken on every rising clk edge where data_in_valid and
// data_in_ready are both high; data_in_ready depends only on registered state,
// so a producer that sees valid && !ready must hold data_in until it is taken.
module uart_tx_buffered #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 10_000_000,
   parameter int DEPTH      = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              data_in,
   input  logic                    data_in_valid,
   output logic                    data_in_ready,
   output logic                    serial_out,
   output logic                    tx_busy,
   output logic [$clog2(DEPTH):0]  fifo_count
);

   localparam int CPB = CLOCK_FREQ / BAUD_RATE;
   localparam int BCW = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;

   localparam logic [BCW-1:0] BAUD_LAST = BCW'(CPB - 1);
   localparam logic [CW-1:0]  FULL      = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_e;

   state_e         state_q, state_d;
   logic [BCW-1:0] baud_q, baud_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     shift_q, shift_d;
   logic           serial_q, serial_d;
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  count_q;
   logic [7:0]     mem_q [DEPTH];

   logic push;
   logic pop;
   logic baud_tc;
   logic fifo_nonempty;

   assign data_in_ready = (count_q != FULL);
   assign push          = data_in_valid && data_in_ready;
   assign fifo_nonempty = (count_q != '0);
   assign baud_tc       = (baud_q == BAUD_LAST);

   assign serial_out = serial_q;
   assign fifo_count = count_q;
   assign tx_busy    = (state_q != S_IDLE) || fifo_nonempty;

   // FIFO storage: written on push, no reset needed since count gates reads.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   // FIFO pointers and occupancy; push and pop together leave count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Shifter state register; the line idles high and returns high on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         serial_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         serial_q <= serial_d;
      end
   end

   // Next-state logic: pop from IDLE or on the last STOP cycle (no inter-frame gap).
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_tc ? '0 : baud_q + BCW'(1);
      bit_d    = bit_q;
      shift_d  = shift_q;
      pop      = 1'b0;
      serial_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (fifo_nonempty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_tc) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_tc) begin
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  shift_d = {1'b0, shift_q[7:1]};
                  bit_d   = bit_q + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (baud_tc) begin
               bit_d = '0;
               if (fifo_nonempty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            baud_d  = '0;
         end
      endcase

      // The line value for the coming cycle follows the state being entered.
      case (state_d)
         S_START: serial_d = 1'b0;
         S_DATA:  serial_d = shift_d[0];
         default: serial_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at CYCLES_PER_BIT=5, DEPTH=8.
// A mid-bit receiver monitor collects frames; expected bytes live in exp_q.
module tb_uart_tx_buffered;

   localparam int CPB   = 5;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       data_in_valid = 1'b0;
   logic       data_in_ready;
   logic       serial_out;
   logic       tx_busy;
   logic [3:0] fifo_count;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   int         rx_t_q[$];
   bit         rx_ok_q[$];

   uart_tx_buffered #(
      .CLOCK_FREQ(50_000_000),
      .BAUD_RATE (10_000_000),
      .DEPTH     (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_in      (data_in),
      .data_in_valid(data_in_valid),
      .data_in_ready(data_in_ready),
      .serial_out   (serial_out),
      .tx_busy      (tx_busy),
      .fifo_count   (fifo_count)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Receiver monitor: detect start at a negedge, sample each bit mid-cell.
   always begin
      logic [7:0] b;
      int         t;
      bit         ok;
      @(negedge clk);
      if (rst_n === 1'b1 && serial_out === 1'b0) begin
         t  = cyc;
         ok = 1'b1;
         b  = 8'h00;
         repeat (CPB / 2) @(negedge clk);
         if (serial_out !== 1'b0) ok = 1'b0;
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = serial_out;
         end
         repeat (CPB) @(negedge clk);
         if (serial_out !== 1'b1) ok = 1'b0;
         rx_q.push_back(b);
         rx_t_q.push_back(t);
         rx_ok_q.push_back(ok);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offer a byte at a negedge, hold until taken (bounded), return at the next negedge.
   task automatic push_byte(input logic [7:0] b);
      int n;
      n = 0;
      data_in       = b;
      data_in_valid = 1'b1;
      while (data_in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("push_accept_in_time", (n < 200), 1);
      if (n < 200) exp_q.push_back(b);
      @(negedge clk);
      data_in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n;
      n = 0;
      while (tx_busy !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check({tag, " drained"}, (n < limit), 1);
      repeat (3) @(negedge clk);
   endtask

   // Scoreboard: received frames against expected bytes, optional 50-cycle spacing.
   task automatic compare_rx(input string tag, input bit gap);
      int         i;
      int         prev;
      logic [7:0] e;
      logic [7:0] r;
      int         t;
      bit         ok;
      i    = 0;
      prev = 0;
      check({tag, " frame_count"}, rx_q.size(), exp_q.size());
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         e  = exp_q.pop_front();
         r  = rx_q.pop_front();
         t  = rx_t_q.pop_front();
         ok = rx_ok_q.pop_front();
         check($sformatf("%s byte%0d", tag, i), r, e);
         check($sformatf("%s framing%0d", tag, i), ok, 1);
         if (gap && i > 0) check($sformatf("%s start_gap%0d", tag, i), t - prev, FRAME);
         prev = t;
         i++;
      end
      exp_q.delete();
      rx_q.delete();
      rx_t_q.delete();
      rx_ok_q.delete();
   endtask

   initial begin
      int         s;
      int         acc;
      int         n;
      int         highs;
      bit         r;
      logic [9:0] fr;

      // reset
      repeat (3) @(negedge clk);
      check("rst serial_out", serial_out, 1);
      check("rst ready", data_in_ready, 1);
      check("rst busy", tx_busy, 0);
      check("rst count", fifo_count, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst serial_out", serial_out, 1);
      check("post_rst busy", tx_busy, 0);

      // single byte 0x41, cycle-exact line check
      push_byte(8'h41);
      check("single pre_start serial", serial_out, 1);
      check("single count", fifo_count, 1);
      check("single busy", tx_busy, 1);
      fr = {1'b1, 8'h41, 1'b0};
      for (int c = 0; c < FRAME; c++) begin
         @(negedge clk);
         check($sformatf("single line c%0d", c), serial_out, fr[c / CPB]);
      end
      check("single busy_last_stop", tx_busy, 1);
      @(negedge clk);
      check("single busy_done", tx_busy, 0);
      check("single idle_line", serial_out, 1);
      check("single count_done", fifo_count, 0);
      repeat (3) @(negedge clk);
      compare_rx("single", 1'b0);

      // back-to-back "Hi"
      push_byte(8'h48);
      push_byte(8'h69);
      wait_idle("b2b", 400);
      compare_rx("b2b", 1'b1);

      // full FIFO with valid held high, bytes 0,1,2,...
      data_in       = 8'h00;
      data_in_valid = 1'b1;
      s             = cyc;
      acc           = 0;
      repeat (20) begin
         r = data_in_ready;
         @(negedge clk);
         if (r) begin
            acc++;
            data_in = 8'(acc);
         end
      end
      check("full accepted", acc, 9);
      check("full ready_low", data_in_ready, 0);
      check("full count", fifo_count, 8);
      n = 0;
      while (data_in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("full ready_rise_cycle", cyc - s, 52);
      check("full count_after_pop", fifo_count, 7);
      check("full next_start", serial_out, 0);
      @(negedge clk);
      data_in_valid = 1'b0;
      check("full refilled", fifo_count, 8);
      for (int i = 0; i < 10; i++) exp_q.push_back(8'(i));
      wait_idle("full", 1000);
      compare_rx("full", 1'b1);

      // push on the exact STOP-end pop cycle with count=3
      s = cyc;
      push_byte(8'hA1);
      push_byte(8'hB2);
      push_byte(8'hC3);
      push_byte(8'hD4);
      repeat (47) @(negedge clk);
      check("same count_before", fifo_count, 3);
      data_in       = 8'hE5;
      data_in_valid = 1'b1;
      exp_q.push_back(8'hE5);
      @(negedge clk);
      data_in_valid = 1'b0;
      check("same cycle_ok", cyc - s, 52);
      check("same count_after", fifo_count, 3);
      check("same next_start", serial_out, 0);
      wait_idle("same", 1000);
      compare_rx("same", 1'b1);

      // reset during DATA bit 3 of 0x55 with two bytes queued
      push_byte(8'h55);
      push_byte(8'h11);
      push_byte(8'h22);
      repeat (21) @(negedge clk);
      check("rst_mid bit3_low", serial_out, 0);
      check("rst_mid queued", fifo_count, 2);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid async_line", serial_out, 1);
      check("rst_mid async_count", fifo_count, 0);
      check("rst_mid async_busy", tx_busy, 0);
      check("rst_mid async_ready", data_in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid count_after", fifo_count, 0);
      highs = 0;
      repeat (100) begin
         @(negedge clk);
         if (serial_out === 1'b1) highs++;
      end
      check("rst_mid line_high_100", highs, 100);
      check("rst_mid busy_after", tx_busy, 0);
      exp_q.delete();
      rx_q.delete();
      rx_t_q.delete();
      rx_ok_q.delete();

      // pointer wrap: 3*DEPTH+3 bytes
      for (int i = 0; i < 27; i++) push_byte(8'((i * 29 + 7) & 8'hFF));
      wait_idle("wrap", 2000);
      compare_rx("wrap", 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter that sits between the CPU's memory-mapped UART transmit register and the `serial_out` pin. It accepts bytes from the CPU over a ready/valid handshake and queues them in an internal FIFO. It then serialises each byte as a 10-bit frame (start bit, 8 data bits LSB first, stop bit) at a fixed baud rate. This frame is what the off-chip host samples mid-bit.

## Interface
- `CLOCK_FREQ`, default 50_000_000: core clock frequency in Hz.
- `BAUD_RATE`, default 10_000_000: serial bit rate.
- `DEPTH`, default 8: FIFO entries; power of two, ≥ 2.
- Derived `CYCLES_PER_BIT` = CLOCK_FREQ / BAUD_RATE (integer divide, must be ≥ 2); 5 at defaults.
- `clk`  in  1  core clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  8  byte to transmit.
- `data_in_valid`  in  1  producer offers `data_in`.
- `data_in_ready`  out  1  block can accept a byte this cycle.
- `serial_out`  out  1  UART line; idle high.
- `tx_busy`  out  1  a frame is in flight or the FIFO is non-empty.
- `fifo_count`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **FIFO**
  - Circular buffer with read/write pointers that wrap at DEPTH.
  - Push when `data_in_valid && data_in_ready`.
  - `data_in_ready` = (`fifo_count` != DEPTH), combinational from registered count.
  - A valid byte offered while not ready is ignored; the producer must hold it.
  - Simultaneous push and pop leaves the count unchanged; both pointers advance.
  - Pop when the shifter is in IDLE, or finishing STOP, and count > 0.
- **Shifter FSM**, states IDLE, START, DATA, STOP.
  - IDLE: `serial_out`=1. If FIFO non-empty, pop into a 8-bit shift register, reset the bit counter and baud counter, go to START.
  - START: `serial_out`=0 for CYCLES_PER_BIT cycles, then DATA.
  - DATA: `serial_out`=shift[0] for CYCLES_PER_BIT cycles per bit, shift right after each bit. After bit 7, go to STOP.
  - STOP: `serial_out`=1 for CYCLES_PER_BIT cycles.
    - On the last STOP cycle, if the FIFO is non-empty, pop and go directly to START. No idle gap between frames.
    - Otherwise go to IDLE.
- Baud counter width is $clog2(CYCLES_PER_BIT). It counts 0..CYCLES_PER_BIT-1 and wraps; the state/bit advance occurs on terminal count.
- `serial_out` is driven from a register (glitch-free).
- `tx_busy` = (state != IDLE) || (`fifo_count` != 0).

## Timing
- **Reset (asynchronous):**
  - `serial_out`=1, `data_in_ready`=1, `tx_busy`=0, `fifo_count`=0, state IDLE.
  - Pointers, counters and shift register are cleared.
- **Reset asserted mid-frame:**
  - The line returns high immediately, without waiting for a clock.
  - Queued bytes are discarded.
  - After deassertion, the block is idle until the next push.
- **Latency:** byte pushed at edge N with FIFO empty and FSM in IDLE.
  - Edge N+1: pop and load; `serial_out` falls at edge N+1.
  - Start bit occupies edges N+1 .. N+CYCLES_PER_BIT.
- **Frame length:** exactly 10·CYCLES_PER_BIT cycles.
- **Back-to-back frames:** with back-to-back data queued, consecutive start bits are exactly 10·CYCLES_PER_BIT cycles apart.
- **`fifo_count` update timing:**
  - Updates on the edge following a push or pop.
  - `data_in_ready` falls in the cycle after the push that filled the FIFO.
  - It rises in the cycle after the pop that relieved it.
- **Throughput:** sustained drain is one byte per 10·CYCLES_PER_BIT cycles. Producer bursts beyond DEPTH+1 bytes are back-pressured.

## Test plan
- **Single byte:** reset, push 0x41 once (CYCLES_PER_BIT=5).
  - `serial_out` bits, 5 cycles each: 0,1,0,0,0,0,0,1,0,1.
  - Then idle high; `tx_busy` returns 0 exactly 50 cycles after the start bit falls.
- **Back-to-back:** push 0x48, 0x69 on consecutive cycles.
  - Two frames with start bits 50 cycles apart and no idle gap.
  - Mid-bit sampling recovers "Hi".
- **Full FIFO:** hold `data_in_valid` high with incrementing bytes from 0x00, with DEPTH=8.
  - Nine bytes accepted (one popped into the shifter, eight queued).
  - Then `data_in_ready`=0 and `fifo_count`=8.
  - Ready reasserts one cycle after the next pop.
  - All bytes are emitted in order with none lost or duplicated.
- **Push and pop in the same cycle:** push on the exact cycle of a STOP-end pop with count=3.
  - Count stays 3 and byte order is preserved.
- **Reset mid-frame:** assert `rst_n`=0 during DATA bit 3 of 0x55 with two bytes queued.
  - `serial_out`=1 with no clock edge needed.
  - After release, `fifo_count`=0 and the line stays high for 100 cycles with no frame.
- **Pointer wrap:** push and drain 3·DEPTH+3 bytes (the 156-char BIOS banner length also works).
  - A receiver model captures the exact sequence across pointer wrap.
